// File: rtl/vend_controller.sv
// -----------------------------------------------------------------------------
// vend_controller
// Vending-machine sequencer. Accumulates coin credit, validates a product
// selection against price and per-slot stock, drives the 3-to-8 slot decoder
// (code + enable) for a fixed dispense window, then pays back any remaining
// credit one coin per cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   coin5        pulse: a 5 coin was inserted
//   coin10       pulse: a 10 coin was inserted
//   sel          product slot code 0..7
//   sel_valid    pulse: sel is a purchase request
//   cancel       pulse: refund the whole credit
//   restock      pulse: reload all slots to STOCK_INIT (honoured in IDLE only)
//   dec_in       slot code towards the decoder (bit0 -> in1 .. bit2 -> in3)
//   dec_enable   decoder enable, high only while dispensing
//   change5      pulse: eject one 5 coin
//   change10     pulse: eject one 10 coin
//   coin_reject  pulse: inserted coin returned, not credited
//   sold_out     pulse: request for an empty slot
//   short_funds  pulse: request with credit below PRICE
//   busy         high while dispensing or returning change
//   credit       current credit
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module vend_controller #(
    parameter int PRICE       = 15,
    parameter int CREDIT_W    = 6,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 5,
    parameter int DISP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin5,
    input  logic                coin10,
    input  logic [2:0]          sel,
    input  logic                sel_valid,
    input  logic                cancel,
    input  logic                restock,
    output logic [2:0]          dec_in,
    output logic                dec_enable,
    output logic                change5,
    output logic                change10,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                short_funds,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    // Largest credit that is still a whole number of 5 coins.
    localparam int CREDIT_MAX_I = ((2**CREDIT_W - 1) / 5) * 5;
    localparam int CNT_W        = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    localparam logic [CREDIT_W:0]   CREDIT_MAX_X = (CREDIT_W+1)'(CREDIT_MAX_I);
    localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] FIVE_C       = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TEN_C        = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] ZERO_C       = {CREDIT_W{1'b0}};
    localparam logic [STOCK_W-1:0]  STOCK_FULL   = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  STOCK_EMPTY  = {STOCK_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_LAST     = CNT_W'(DISP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO     = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [CREDIT_W-1:0]  credit_r, credit_s;
    logic [STOCK_W-1:0]   stock_r [8];
    logic [STOCK_W-1:0]   stock_s [8];
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [2:0]           dec_in_r, dec_in_s;
    logic                 dec_enable_r, dec_enable_s;
    logic                 change5_r, change5_s;
    logic                 change10_r, change10_s;
    logic                 coin_reject_r, coin_reject_s;
    logic                 sold_out_r, sold_out_s;
    logic                 short_funds_r, short_funds_s;
    logic                 busy_r, busy_s;

    // Coin acceptance helpers (used only in states that take coins).
    logic [CREDIT_W:0]    sum5_s, sum10_s;
    logic [CREDIT_W-1:0]  coin_credit_s;
    logic                 coin_ok_s, coin_bad_s;

    assign sum5_s  = {1'b0, credit_r} + {1'b0, FIVE_C};
    assign sum10_s = {1'b0, credit_r} + {1'b0, TEN_C};

    // Credit after the coins of this cycle; coin10 wins when both arrive.
    always_comb begin
        coin_credit_s = credit_r;
        coin_ok_s     = 1'b0;
        coin_bad_s    = 1'b0;
        if (coin10) begin
            if (sum10_s <= CREDIT_MAX_X) begin
                coin_credit_s = sum10_s[CREDIT_W-1:0];
                coin_ok_s     = 1'b1;
            end else begin
                coin_bad_s    = 1'b1;
            end
            if (coin5) begin
                coin_bad_s    = 1'b1;
            end else begin
                coin_bad_s    = coin_bad_s;
            end
        end else if (coin5) begin
            if (sum5_s <= CREDIT_MAX_X) begin
                coin_credit_s = sum5_s[CREDIT_W-1:0];
                coin_ok_s     = 1'b1;
            end else begin
                coin_bad_s    = 1'b1;
            end
        end else begin
            coin_ok_s = 1'b0;
        end
    end

    // Next-state, datapath and next-output logic of the sequencer.
    always_comb begin
        state_s       = state_r;
        credit_s      = credit_r;
        stock_s       = stock_r;
        cnt_s         = cnt_r;
        dec_in_s      = dec_in_r;
        change5_s     = 1'b0;
        change10_s    = 1'b0;
        coin_reject_s = 1'b0;
        sold_out_s    = 1'b0;
        short_funds_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (sel_valid) begin
                    // Nothing credited yet, so any request is short of funds.
                    short_funds_s = 1'b1;
                    coin_reject_s = coin5 | coin10;
                end else begin
                    credit_s      = coin_credit_s;
                    coin_reject_s = coin_bad_s;
                    if (coin_ok_s) begin
                        state_s = ST_COLLECT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                if (restock) begin
                    for (int i = 0; i < 8; i++) begin
                        stock_s[i] = STOCK_FULL;
                    end
                end else begin
                    stock_s = stock_r;
                end
            end

            ST_COLLECT: begin
                if (cancel) begin
                    coin_reject_s = coin5 | coin10;
                    state_s       = ST_CHANGE;
                end else if (sel_valid) begin
                    coin_reject_s = coin5 | coin10;
                    if (stock_r[sel] == STOCK_EMPTY) begin
                        sold_out_s = 1'b1;
                    end else if (credit_r < PRICE_C) begin
                        short_funds_s = 1'b1;
                    end else begin
                        dec_in_s     = sel;
                        credit_s     = credit_r - PRICE_C;
                        stock_s[sel] = stock_r[sel] - STOCK_W'(1);
                        cnt_s        = CNT_ZERO;
                        state_s      = ST_DISPENSE;
                    end
                end else begin
                    credit_s      = coin_credit_s;
                    coin_reject_s = coin_bad_s;
                end
            end

            ST_DISPENSE: begin
                coin_reject_s = coin5 | coin10;
                if (cnt_r == CNT_LAST) begin
                    if (credit_r != ZERO_C) begin
                        state_s = ST_CHANGE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            ST_CHANGE: begin
                coin_reject_s = coin5 | coin10;
                if (credit_r == ZERO_C) begin
                    state_s = ST_IDLE;
                end else if (credit_r >= TEN_C) begin
                    change10_s = 1'b1;
                    credit_s   = credit_r - TEN_C;
                end else if (credit_r >= FIVE_C) begin
                    change5_s  = 1'b1;
                    credit_s   = credit_r - FIVE_C;
                end else begin
                    // Unreachable residue below one coin: clear rather than underflow.
                    credit_s   = ZERO_C;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                credit_s = ZERO_C;
            end
        endcase

        dec_enable_s = (state_s == ST_DISPENSE);
        busy_s       = (state_s == ST_DISPENSE) || (state_s == ST_CHANGE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            credit_r      <= ZERO_C;
            for (int i = 0; i < 8; i++) begin
                stock_r[i] <= STOCK_FULL;
            end
            cnt_r         <= CNT_ZERO;
            dec_in_r      <= 3'd0;
            dec_enable_r  <= 1'b0;
            change5_r     <= 1'b0;
            change10_r    <= 1'b0;
            coin_reject_r <= 1'b0;
            sold_out_r    <= 1'b0;
            short_funds_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            credit_r      <= credit_s;
            stock_r       <= stock_s;
            cnt_r         <= cnt_s;
            dec_in_r      <= dec_in_s;
            dec_enable_r  <= dec_enable_s;
            change5_r     <= change5_s;
            change10_r    <= change10_s;
            coin_reject_r <= coin_reject_s;
            sold_out_r    <= sold_out_s;
            short_funds_r <= short_funds_s;
            busy_r        <= busy_s;
        end
    end

    assign dec_in      = dec_in_r;
    assign dec_enable  = dec_enable_r;
    assign change5     = change5_r;
    assign change10    = change10_r;
    assign coin_reject = coin_reject_r;
    assign sold_out    = sold_out_r;
    assign short_funds = short_funds_r;
    assign busy        = busy_r;
    assign credit      = credit_r;

endmodule
